hamming_enc_arbiter: RTL
========================

// Module: hamming_enc_arbiter
// PURPOSE
//  Shares one Hamming(7,4) encoder datapath between NUM_REQ requesters.
//  Round-robin arbiter with valid/ready on each input, one registered output
//  slot carrying the 7-bit codeword and the requester ID.
//  Sits between the per-channel data producers and the protected storage/link.
// PARAMETERS
//  NUM_REQ   4   number of requesters (2..16)
//  ID_BITS   2   width of OUT_ID; must satisfy 2**ID_BITS >= NUM_REQ
// PORTS
//  CLK        in   1           rising-edge clock
//  RST_N      in   1           asynchronous active-low reset
//  REQ_VALID  in   NUM_REQ     per-requester data valid
//  REQ_DATA   in   4*NUM_REQ   requester i data at [4i+3:4i]
//  REQ_READY  out  NUM_REQ     one-hot grant/accept, combinational
//  OUT_VALID  out  1           output slot holds a codeword
//  OUT_CODE   out  7           Hamming(7,4) codeword
//  OUT_ID     out  ID_BITS     index of the requester that produced OUT_CODE
//  OUT_READY  in   1           consumer accepts the output slot
// BEHAVIOUR
//  - Reset (RST_N=0, async): OUT_VALID=0, OUT_CODE=0, OUT_ID=0, state=EMPTY,
//    rr_ptr=NUM_REQ-1, so requester 0 has first priority.
//  - Encoding, d=granted data: CW[0]=d0, CW[1]=d1, CW[2]=d2, CW[4]=d3,
//    CW[3]=d3^d2^d0, CW[5]=d3^d1^d0, CW[6]=d2^d1^d0.
//  - slot_free = (state==EMPTY) | OUT_READY.
//  - Grant: if slot_free, REQ_READY[i]=1 only for the first i with REQ_VALID[i]=1,
//    searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ. Otherwise REQ_READY=0.
//  - Accept when REQ_VALID[i]&REQ_READY[i]. Next edge: OUT_CODE=CW, OUT_ID=i,
//    OUT_VALID=1, rr_ptr=i. Latency is 1 cycle.
//  - FSM states:
//    - EMPTY->FULL on accept.
//    - FULL->EMPTY on OUT_READY with no accept.
//    - FULL->FULL on OUT_READY together with an accept (simultaneous drain and
//      refill).
//    - FULL holds on !OUT_READY. OUT_CODE and OUT_ID stay stable while FULL and
//      not drained.
//  - Throughput is 1 codeword/cycle with OUT_READY held high.
//  - Idle: no valid requests leaves rr_ptr unchanged.
//  - A requester that drops REQ_VALID without a grant is legal.
//  - Pointer wrap: from NUM_REQ-1 the search continues at 0.
//  - Reset mid-operation discards the slot and returns priority to requester 0.
// CONFIGURATION
//  HAM_ARB_ERRINJ_EN defined:
//  - Adds ports ERRINJ_VALID (in, 1) and ERRINJ_BIT (in, 3).
//  - On an accept cycle with ERRINJ_VALID=1 and ERRINJ_BIT<7, stored
//    CW[ERRINJ_BIT] is inverted.
//  - ERRINJ_BIT=7 leaves the codeword unmodified.
//  - No effect on cycles without an accept.
//  HAM_ARB_ERRINJ_EN undefined:
//  - These ports do not exist and the codeword is never modified.
// TESTING
//  1. Reset, REQ_VALID=0001, data0=4'hB, OUT_READY=1
//     -> REQ_READY=0001; next cycle OUT_VALID=1, OUT_CODE=7'h33, OUT_ID=0.
//  2. All four valid, OUT_READY=1 for 8 cycles
//     -> OUT_ID sequence 0,1,2,3,0,1,2,3; no gaps in OUT_VALID.
//  3. Slot FULL, OUT_READY=0 for 3 cycles
//     -> REQ_READY=0, OUT_CODE/OUT_ID stable. OUT_READY=1 -> next grant issued
//     in the same cycle.
//  4. Data 4'h0 -> 7'h00; 4'hF -> 7'h7F; every other value of d -> codeword
//     matches the encoding equations.
//  5. RST_N pulsed low while FULL with rr_ptr=2
//     -> OUT_VALID=0 immediately; with all requests valid the next grant goes
//     to requester 0.
//  6. (HAM_ARB_ERRINJ_EN) data 4'hB, ERRINJ_BIT=0 -> OUT_CODE=7'h32;
//     ERRINJ_BIT=7 -> 7'h33.

Source files
------------

// File: rtl/hamming_enc_arbiter.sv
// Round-robin arbiter in front of a shared Hamming(7,4) encoder with a single
// registered output slot (codeword + requester id).
// Optional build macro: HAM_ARB_ERRINJ_EN adds single-bit error injection on accept.
module hamming_enc_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [4*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  output logic [6:0]           out_code,
  output logic [ID_BITS-1:0]   out_id,
`ifdef HAM_ARB_ERRINJ_EN
  input  logic                 errinj_valid,
  input  logic [2:0]           errinj_bit,
`endif
  input  logic                 out_ready
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic               state_q, state_d;
  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [6:0]         code_q, code_d;
  logic [ID_BITS-1:0] id_q, id_d;

  logic               found;
  logic [ID_BITS-1:0] gnt_id;
  logic [3:0]         gnt_data;
  logic               slot_free;
  logic               accept;
  logic [6:0]         cw;
  logic [6:0]         cw_stored;

  assign slot_free = (state_q == StEmpty) | out_ready;
  assign accept    = slot_free & found;

  // Round-robin search starting just after the last granted requester.
  // Nested loops keep every index constant after unrolling.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (i == (32'(rr_ptr_q) + k) % NUM_REQ)) begin
          found  = 1'b1;
          gnt_id = ID_BITS'(i);
        end
      end
    end
  end

  // One-hot ready and data mux for the winning requester.
  always_comb begin
    req_ready = '0;
    gnt_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_BITS'(i)) begin
        req_ready[i] = slot_free & found;
        gnt_data     = req_data[4*i +: 4];
      end
    end
  end

  // Hamming(7,4) encode with parity bits at positions 3, 5 and 6.
  always_comb begin
    cw[0] = gnt_data[0];
    cw[1] = gnt_data[1];
    cw[2] = gnt_data[2];
    cw[4] = gnt_data[3];
    cw[3] = gnt_data[3] ^ gnt_data[2] ^ gnt_data[0];
    cw[5] = gnt_data[3] ^ gnt_data[1] ^ gnt_data[0];
    cw[6] = gnt_data[2] ^ gnt_data[1] ^ gnt_data[0];
  end

  // Optional single-bit corruption of the codeword being captured.
  always_comb begin
    cw_stored = cw;
`ifdef HAM_ARB_ERRINJ_EN
    // Bit index 7 is the "no injection" encoding.
    if (errinj_valid && (errinj_bit != 3'd7)) begin
      cw_stored[errinj_bit] = ~cw[errinj_bit];
    end
`endif
  end

  // Slot next state: refill on accept (even while draining), else empty on drain.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    code_d   = code_q;
    id_d     = id_q;
    if (accept) begin
      state_d  = StFull;
      rr_ptr_d = gnt_id;
      code_d   = cw_stored;
      id_d     = gnt_id;
    end else if (out_ready) begin
      state_d = StEmpty;
    end
  end

  // Slot registers; reset leaves pointer at the last id so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      rr_ptr_q <= ID_BITS'(NUM_REQ - 1);
      code_q   <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      code_q   <= code_d;
      id_q     <= id_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign out_code  = code_q;
  assign out_id    = id_q;

endmodule
